// File: rtl/weight_ram_loader.sv
// Streams weight bytes over valid/ready into the 128 x 8 weight RAM write port.
// Define WEIGHT_CHECKSUM_EN to require a trailing checksum byte and add checksum_err.
module weight_ram_loader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hold,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_written,
    output logic              wrapped
`ifdef WEIGHT_CHECKSUM_EN
    ,
    output logic              checksum_err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  remaining;
    logic              accept;
    logic              data_phase;

`ifdef WEIGHT_CHECKSUM_EN
    logic [7:0]        sum;
    logic [7:0]        sum_next;

    // Once every data byte is in, the next accepted byte is the checksum.
    assign data_phase = (remaining != '0);
    assign sum_next   = sum + 8'(in_data);
`else
    assign data_phase = 1'b1;
`endif

    assign in_ready = (state == LOAD) && !hold;
    assign accept   = in_valid && in_ready;

    // NOTE: all state and registered outputs are updated with non-blocking
    // assignments so every branch sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ptr           <= '0;
            remaining     <= '0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_din       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
            wrapped       <= 1'b0;
`ifdef WEIGHT_CHECKSUM_EN
            sum           <= '0;
            checksum_err  <= 1'b0;
`endif
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr           <= base_addr;
                        remaining     <= length;
                        words_written <= '0;
                        wrapped       <= 1'b0;
                        busy          <= 1'b1;
`ifdef WEIGHT_CHECKSUM_EN
                        sum           <= '0;
                        checksum_err  <= 1'b0;
                        state         <= LOAD;
`else
                        if (length == '0) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            state <= LOAD;
                        end
`endif
                    end
                end

                LOAD: begin
                    if (accept) begin
                        if (data_phase) begin
                            ram_we        <= 1'b1;
                            ram_addr      <= ptr;
                            ram_din       <= in_data;
                            ptr           <= ptr + 1'b1;
                            remaining     <= remaining - LEN_W'(1);
                            words_written <= words_written + LEN_W'(1);
                            if (ptr == '1) begin
                                wrapped <= 1'b1;
                            end
                        end
`ifdef WEIGHT_CHECKSUM_EN
                        sum <= sum_next;
                        if (!data_phase) begin
                            checksum_err <= (sum_next != 8'h00);
                            done         <= 1'b1;
                            state        <= FINISH;
                        end
`else
                        if (remaining == LEN_W'(1)) begin
                            state <= FINISH;
                        end
`endif
                    end
                end

                FINISH: begin
                    // Entries with no write in flight raise done on the way in;
                    // otherwise done follows the final write by one cycle.
                    done  <= !done;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_ram_loader.sv
// Scoreboard bench for weight_ram_loader: expected RAM writes are queued at accept
// time and compared by a write monitor; define WEIGHT_CHECKSUM_EN to cover the checksum build.
module tb_weight_ram_loader;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              hold = 1'b0;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  words_written;
    logic              wrapped;
`ifdef WEIGHT_CHECKSUM_EN
    logic              checksum_err;
`endif

    int checks     = 0;
    int failures   = 0;
    int done_count = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] exp_w;
    logic [ADDR_W-1:0]        model_ptr = '0;
    logic [7:0]               model_sum = '0;

    weight_ram_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .hold         (hold),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .busy         (busy),
        .done         (done),
        .words_written(words_written),
        .wrapped      (wrapped)
`ifdef WEIGHT_CHECKSUM_EN
        ,
        .checksum_err (checksum_err)
`endif
    );

    always #5 clk = ~clk;

    // Write monitor: every RAM write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (ram_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ram_write_unexpected addr=%0h data=%0h required=no write", ram_addr, ram_din);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({ram_addr, ram_din} !== exp_w) begin
                        failures++;
                        $display("FAIL ram_write addr=%0h data=%0h required addr=%0h data=%0h",
                                 ram_addr, ram_din, exp_w[DATA_W +: ADDR_W], exp_w[DATA_W-1:0]);
                    end
                end
            end
            if (done === 1'b1) done_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        model_ptr = b;
        model_sum = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte with in_valid held high; returns at the negedge after acceptance.
    task automatic send_byte(input logic [DATA_W-1:0] b, input bit is_data);
        int n;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        #1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout data=%0h in_ready=%b required=1", b, in_ready);
        end else begin
            if (is_data) begin
                exp_q.push_back({model_ptr, b});
                model_ptr++;
            end
            model_sum += 8'(b);
        end
        @(negedge clk);
    endtask

    task automatic end_load();
`ifdef WEIGHT_CHECKSUM_EN
        send_byte(DATA_W'(-model_sum), 1'b0);
`endif
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_timeout done=%b required=1", name, done);
        end
    endtask

    task automatic finish_and_check(input string name, input int dc_before,
                                    input logic [LEN_W-1:0] exp_words, input logic exp_wrapped);
        end_load();
        wait_done(name);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done_count !== dc_before + 1) begin
            failures++;
            $display("FAIL %s done_pulses got=%0d required=1", name, done_count - dc_before);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL %s missing_writes got=%0d required=0", name, exp_q.size());
        end
        checks++;
        if (words_written !== exp_words) begin
            failures++;
            $display("FAIL %s words_written got=%0d required=%0d", name, words_written, exp_words);
        end
        checks++;
        if (wrapped !== exp_wrapped) begin
            failures++;
            $display("FAIL %s wrapped got=%b required=%b", name, wrapped, exp_wrapped);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_after got=%b required=0", name, busy);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({in_ready, ram_we, busy, done, wrapped} !== 5'b0 || ram_addr !== '0 ||
            ram_din !== '0 || words_written !== '0) begin
            failures++;
            $display("FAIL %s outputs rdy=%b we=%b busy=%b done=%b wrap=%b addr=%0h din=%0h ww=%0d required all 0",
                     name, in_ready, ram_we, busy, done, wrapped, ram_addr, ram_din, words_written);
        end
`ifdef WEIGHT_CHECKSUM_EN
        checks++;
        if (checksum_err !== 1'b0) begin
            failures++;
            $display("FAIL %s checksum_err got=%b required=0", name, checksum_err);
        end
`endif
    endtask

    task automatic test_reset();
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int dc;
        dc = done_count;
        do_start(7'h00, 8'd4);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
`ifndef WEIGHT_CHECKSUM_EN
        in_valid = 1'b0;
        checks++;
        if (ram_we !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_last_write we=%b done=%b required we=1 done=0", ram_we, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_timing done=%b we=%b required done=1 we=0", done, ram_we);
        end
`endif
        finish_and_check("basic", dc, 8'd4, 1'b0);
    endtask

    task automatic test_wrap();
        int dc;
        dc = done_count;
        do_start(7'h7E, 8'd3);
        send_byte(8'hA0, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        finish_and_check("wrap", dc, 8'd3, 1'b1);
    endtask

    task automatic test_hold();
        int dc;
        dc = done_count;
        do_start(7'h10, 8'd4);
        send_byte(8'h51, 1'b1);
        send_byte(8'h52, 1'b1);
        hold     = 1'b1;
        in_data  = 8'h53;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_in_ready cycle=%0d got=%b required=0", i, in_ready);
            end
            @(negedge clk);
        end
        hold = 1'b0;
        send_byte(8'h53, 1'b1);
        send_byte(8'h54, 1'b1);
        finish_and_check("hold", dc, 8'd4, 1'b0);
    endtask

    task automatic test_zero_length();
        int dc;
        dc = done_count;
        do_start(7'h50, 8'd0);
`ifndef WEIGHT_CHECKSUM_EN
        checks++;
        if (done !== 1'b1 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_done done=%b we=%b required done=1 we=0", done, ram_we);
        end
`endif
        finish_and_check("zero_len", dc, 8'd0, 1'b0);
    endtask

    task automatic test_ignored_start();
        int dc;
        dc = done_count;
        do_start(7'h40, 8'd3);
        send_byte(8'hC1, 1'b1);
        in_valid  = 1'b0;
        base_addr = 7'h00;
        length    = 8'd5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || words_written !== 8'd1) begin
            failures++;
            $display("FAIL ignored_start busy=%b ww=%0d required busy=1 ww=1", busy, words_written);
        end
        send_byte(8'hC2, 1'b1);
        send_byte(8'hC3, 1'b1);
        finish_and_check("ignored_start", dc, 8'd3, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        int dc;
        do_start(7'h20, 8'd8);
        send_byte(8'h61, 1'b1);
        send_byte(8'h62, 1'b1);
        send_byte(8'h63, 1'b1);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid_load");
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL reset_mid_load pending_writes got=%0d required=0", exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        dc = done_count;
        do_start(7'h05, 8'd2);
        send_byte(8'h71, 1'b1);
        send_byte(8'h72, 1'b1);
        finish_and_check("after_reset", dc, 8'd2, 1'b0);
    endtask

`ifdef WEIGHT_CHECKSUM_EN
    task automatic test_checksum();
        do_start(7'h30, 8'd2);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hFD, 1'b0);
        in_valid = 1'b0;
        wait_done("checksum_good");
        checks++;
        if (checksum_err !== 1'b0 || words_written !== 8'd2) begin
            failures++;
            $display("FAIL checksum_good err=%b ww=%0d required err=0 ww=2", checksum_err, words_written);
        end
        @(negedge clk);
        do_start(7'h32, 8'd2);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hFC, 1'b0);
        in_valid = 1'b0;
        wait_done("checksum_bad");
        checks++;
        if (checksum_err !== 1'b1 || words_written !== 8'd2) begin
            failures++;
            $display("FAIL checksum_bad err=%b ww=%0d required err=1 ww=2", checksum_err, words_written);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL checksum missing_writes got=%0d required=0", exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_hold();
        test_zero_length();
        test_ignored_start();
        test_reset_mid_load();
`ifdef WEIGHT_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
